// File: rtl/shift_pkg.sv
// Shared encodings for the multicycle shifter and the control FSM that drives it.
// Op codes live here so the control FSM and the shifter cannot disagree on them.
package shift_pkg;

   localparam int SHIFT_WIDTH   = 32;
   localparam int SHIFT_SHAMT_W = 5;

   typedef enum logic [1:0] {
      SH_SLL  = 2'b00,
      SH_SRL  = 2'b01,
      SH_SRA  = 2'b10,
      SH_PASS = 2'b11
   } shift_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } shift_state_t;

   // PASS never moves bits, so it skips the SHIFT state whatever the amount is.
   function automatic logic is_shift_op(input shift_op_t op);
      return (op != SH_PASS);
   endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit shift of r by op; the top applies it once per SHIFT cycle.
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] r,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] r_nxt
);

   always_comb begin
      r_nxt = r;
      case (shift_op_t'(op))
         SH_SLL:  r_nxt = {r[WIDTH-2:0], 1'b0};
         SH_SRL:  r_nxt = {1'b0, r[WIDTH-1:1]};
         SH_SRA:  r_nxt = {r[WIDTH-1], r[WIDTH-1:1]};
         default: r_nxt = r;
      endcase
   end

endmodule

// File: rtl/shift_seq_unit.sv
// Multicycle shifter: latches operand/amount/op on start, shifts one bit per cycle,
// then pulses done for one cycle with the result held until the next accepted start.
module shift_seq_unit
   import shift_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [1:0]         shift_op,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [WIDTH-1:0]   data_in,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result,
   output logic [1:0]         dbg_state
);

   // Handshake: start is a request taken only in IDLE (busy=0); a start seen
   // while busy is dropped, not queued. done is a one-cycle valid for result,
   // with no ready -- the consumer must sample result in the done cycle.
   // SHAMT_W must satisfy 2**SHAMT_W == WIDTH so count never needs to hold WIDTH.

   shift_state_t       state_q, state_d;
   shift_op_t          op_q;
   logic [SHAMT_W-1:0] count_q;
   logic [WIDTH-1:0]   step_out;
   logic               accept;
   logic               last_step;

   assign accept    = (state_q == ST_IDLE) && start;
   assign last_step = (count_q == SHAMT_W'(1));

   shift_step #(.WIDTH(WIDTH)) u_step (
      .r     (result),
      .op    (op_q),
      .r_nxt (step_out)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if ((shamt != '0) && is_shift_op(shift_op_t'(shift_op))) begin
                  state_d = ST_SHIFT;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_SHIFT: begin
            if (last_step) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
      done      = (state_q == ST_DONE);
      dbg_state = state_q;
   end

   // Datapath registers; result only moves on an accepted start or in SHIFT,
   // so it is stable through IDLE and DONE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         result  <= '0;
         count_q <= '0;
         op_q    <= SH_PASS;
      end else if (accept) begin
         result  <= data_in;
         count_q <= shamt;
         op_q    <= shift_op_t'(shift_op);
      end else if (state_q == ST_SHIFT) begin
         result  <= step_out;
         count_q <= count_q - SHAMT_W'(1);
      end
   end

endmodule

// File: tb/tb_shift_seq_unit.sv
// Bench for shift_seq_unit: directed cases plus random ops, checked through a
// scoreboard of expected results and done cycles.
module tb_shift_seq_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start;
   logic [1:0]   shift_op;
   logic [4:0]   shamt;
   logic [W-1:0] data_in;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic [1:0]   dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_done   = 0;
   bit prev_done = 1'b0;

   logic [W-1:0] exp_q[$];
   int           exp_cyc_q[$];

   shift_seq_unit dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .shift_op  (shift_op),
      .shamt     (shamt),
      .data_in   (data_in),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .dbg_state (dbg_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] d,
                                          input logic [4:0] s);
      case (op)
         2'b00:   return d << s;
         2'b01:   return d >> s;
         2'b10:   return $unsigned($signed(d) >>> s);
         default: return d;
      endcase
   endfunction

   // scoreboard monitor
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_done = 1'b0;
      end else begin
         if (done) begin
            check("done_gap", {31'b0, prev_done}, 0);
            check("done_expected", {31'b0, exp_q.size() != 0}, 1);
            if (exp_q.size() != 0) begin
               check("result", result, exp_q.pop_front());
               check("done_cycle", cyc, exp_cyc_q.pop_front());
            end
            n_done++;
         end
         prev_done = done;
      end
   end

   task automatic wait_idle();
      int i;
      for (i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      if (i == 200) check("idle_timeout", {31'b0, busy}, 0);
   endtask

   task automatic do_op(input logic [1:0] op, input logic [W-1:0] d, input logic [4:0] s,
                        output int acc);
      wait_idle();
      start    = 1'b1;
      shift_op = op;
      data_in  = d;
      shamt    = s;
      acc      = cyc + 1;
      exp_q.push_back(model(op, d, s));
      exp_cyc_q.push_back(acc + ((op == 2'b11) ? 0 : int'(s)));
      @(negedge clk);
      start    = 1'b0;
      shift_op = 2'($urandom);
      data_in  = $urandom;
      shamt    = 5'($urandom);
   endtask

   initial begin
      int acc, d0, k;
      reset_n  = 1'b0;
      start    = 1'b0;
      shift_op = 2'b00;
      shamt    = '0;
      data_in  = '0;
      repeat (3) @(negedge clk);
      check("reset_result", result, 0);
      check("reset_busy", {31'b0, busy}, 0);
      check("reset_done", {31'b0, done}, 0);
      check("reset_state", {30'b0, dbg_state}, 0);
      reset_n = 1'b1;

      // SLL by 4, with busy sampled mid-operation
      do_op(2'b00, 32'h0000_0001, 5'd4, acc);
      @(negedge clk);
      check("busy_mid", {31'b0, busy}, 1);

      // full-range shifts
      do_op(2'b10, 32'h8000_0000, 5'd31, acc);
      do_op(2'b01, 32'h8000_0000, 5'd31, acc);

      // zero amount and PASS
      do_op(2'b00, 32'hDEAD_BEEF, 5'd0, acc);
      do_op(2'b11, 32'hDEAD_BEEF, 5'd7, acc);

      // start during SHIFT is ignored
      wait_idle();
      d0 = n_done;
      do_op(2'b00, 32'h0000_0001, 5'd8, acc);
      repeat (2) @(negedge clk);
      start    = 1'b1;
      shift_op = 2'b10;
      data_in  = 32'hFFFF_FFFF;
      shamt    = 5'd3;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      @(negedge clk);
      check("single_done", n_done - d0, 1);

      // reset mid-SHIFT
      do_op(2'b01, 32'hF000_0000, 5'd16, acc);
      repeat (5) @(negedge clk);
      check("mid_shift", result, 32'h0780_0000);
      reset_n = 1'b0;
      #1;
      check("rst_result", result, 0);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_done", {31'b0, done}, 0);
      exp_q.delete();
      exp_cyc_q.delete();
      d0 = n_done;
      repeat (20) @(negedge clk);
      check("no_done_in_reset", n_done, d0);
      reset_n = 1'b1;
      do_op(2'b01, 32'hF000_0000, 5'd16, acc);

      // start held high: one op every shamt+2 cycles
      wait_idle();
      d0       = n_done;
      k        = cyc;
      start    = 1'b1;
      shift_op = 2'b00;
      shamt    = 5'd3;
      data_in  = 32'h0000_00A5;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(32'h0000_0528);
         exp_cyc_q.push_back(k + 1 + 5 * i + 3);
      end
      repeat (20) @(negedge clk);
      start = 1'b0;
      wait_idle();
      check("held_start_ops", n_done - d0, 4);

      // random ops
      for (int i = 0; i < 12; i++) begin
         do_op(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), acc);
      end

      wait_idle();
      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
